adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered 8-bit `adder` instance between `N_REQ` requesters. It accepts one add request per cycle over a valid/ready handshake and drives the adder operand ports from registers. It returns the registered sum with the winning requester's ID after a fixed latency. It sits between requester blocks and the `adder` datapath (`x`, `y`, `cin` in; `sm`, `sm_r`, `sm_zero_r` out).

---
 rtl/adder_arbiter.sv | 140 ++++++++++++++
 tb/tb_adder_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that shares one registered 8-bit adder
// between N_REQ requesters. One transfer per cycle over valid/ready; the
// registered sum returns with the winner's ID two edges after the transfer.
// Optional feature: define ADDER_ARB_LOCK_EN for locked multi-beat bursts
// that chain the adder carry between beats.
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*8-1:0]   req_x,
    input  logic [N_REQ*8-1:0]   req_y,
    input  logic [N_REQ-1:0]     req_cin,
`ifdef ADDER_ARB_LOCK_EN
    input  logic [N_REQ-1:0]     req_last,
`endif
    output logic [7:0]           add_x,
    output logic [7:0]           add_y,
    output logic                 add_cin,
`ifdef ADDER_ARB_LOCK_EN
    input  logic [8:0]           add_sm,
`endif
    input  logic [8:0]           add_sm_r,
    input  logic                 add_sm_zero_r,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [8:0]           rsp_sum,
    output logic                 rsp_zero
);

    typedef enum logic [1:0] {IDLE, ISSUE, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr;          // round-robin priority pointer
    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic              xfer;
    logic              win_last;
    logic [N_REQ-1:0]  elig;         // requesters allowed to win this cycle
    int                cand;
    logic              s1_vld;       // issue flag, pipeline stage 1
    logic [ID_W-1:0]   s1_id;

`ifdef ADDER_ARB_LOCK_EN
    logic [ID_W-1:0]   owner;        // requester holding the lock
    logic              unused_sm_low;
    assign unused_sm_low = &{1'b0, add_sm[7:0]};
    // While locked only the owner may be granted.
    assign elig     = (state == LOCKED) ? (N_REQ'(1) << owner) : '1;
    assign win_last = req_last[grant_idx];
`else
    assign elig     = '1;
    assign win_last = 1'b1;
`endif

    // Pick the first eligible valid requester at or after the pointer.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!grant_found && req_valid[cand] && elig[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    assign req_ready = (grant_found && !rst) ? (N_REQ'(1) << grant_idx) : '0;
    assign xfer      = grant_found && !rst;
    assign ptr_nxt   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Next-state logic for the issue/lock FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ISSUE: begin
                if (xfer) state_nxt = win_last ? ISSUE : LOCKED;
                else      state_nxt = IDLE;
            end
            LOCKED: begin
                if (xfer && win_last) state_nxt = ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand registers, pointer and the two-stage response pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_x     <= '0;
            add_y     <= '0;
            add_cin   <= 1'b0;
            ptr       <= '0;
            s1_vld    <= 1'b0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
`ifdef ADDER_ARB_LOCK_EN
            owner     <= '0;
`endif
        end else begin
            s1_vld    <= xfer;
            rsp_valid <= s1_vld;
            rsp_id    <= s1_id;
            if (xfer) begin
                add_x <= req_x[{grant_idx, 3'b000} +: 8];
                add_y <= req_y[{grant_idx, 3'b000} +: 8];
`ifdef ADDER_ARB_LOCK_EN
                // Later beats of a burst chain the carry of the previous beat.
                add_cin <= (state == LOCKED) ? add_sm[8] : req_cin[grant_idx];
                owner   <= grant_idx;
`else
                add_cin <= req_cin[grant_idx];
`endif
                // During a lock grant_idx is the owner, so the pointer stays
                // parked just past it and is still there on release.
                ptr   <= ptr_nxt;
                s1_id <= grant_idx;
            end
        end
    end

    assign rsp_sum  = add_sm_r;
    assign rsp_zero = add_sm_zero_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter with a behavioural
// registered adder. Lock burst vectors run when ADDER_ARB_LOCK_EN is defined.
module tb_adder_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*8-1:0] req_x = '0;
    logic [N_REQ*8-1:0] req_y = '0;
    logic [N_REQ-1:0]   req_cin = '0;
`ifdef ADDER_ARB_LOCK_EN
    logic [N_REQ-1:0]   req_last = '1;
`endif
    logic [7:0]         add_x, add_y;
    logic               add_cin;
    logic [8:0]         add_sm, add_sm_r;
    logic               add_sm_zero_r;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [8:0]         rsp_sum;
    logic               rsp_zero;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int       id;
        int       sum;
        int       zero;
        int       due;
    } exp_t;
    exp_t exp_q[$];

    // Hand-computed table: x, y, cin and resulting 9-bit sum per requester.
    logic [7:0] tx   [N_REQ] = '{8'h10, 8'h20, 8'h30, 8'hF0};
    logic [7:0] ty   [N_REQ] = '{8'h03, 8'h04, 8'h05, 8'h20};
    logic       tc   [N_REQ] = '{1'b0,  1'b1,  1'b0,  1'b1};
    int         tsum [N_REQ] = '{'h013, 'h025, 'h035, 'h111};

    adder_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
`ifdef ADDER_ARB_LOCK_EN
        .req_last(req_last),
`endif
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
`ifdef ADDER_ARB_LOCK_EN
        .add_sm(add_sm),
`endif
        .add_sm_r(add_sm_r), .add_sm_zero_r(add_sm_zero_r),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    // Behavioural registered adder.
    assign add_sm = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};
    always @(posedge clk) begin
        add_sm_r      <= add_sm;
        add_sm_zero_r <= (add_sm == 9'd0);
        cyc           <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y,
                           input logic c);
        req_x[i*8 +: 8] = x;
        req_y[i*8 +: 8] = y;
        req_cin[i]      = c;
    endtask

    task automatic load_table();
        for (int i = 0; i < N_REQ; i++) set_req(i, tx[i], ty[i], tc[i]);
    endtask

    // Expect a response for a transfer at the coming edge.
    task automatic expect_rsp(input int id, input int sum, input int zero);
        exp_t e;
        e.id = id; e.sum = sum; e.zero = zero; e.due = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic grant_is(input string name, input int onehot);
        #1;
        check(name, int'(req_ready), onehot);
    endtask

    // Monitor: pop and compare whenever the DUT presents a response.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_id",    int'(rsp_id),   e.id);
                check("rsp_sum",   int'(rsp_sum),  e.sum);
                check("rsp_zero",  int'(rsp_zero), e.zero);
                check("rsp_cycle", cyc,            e.due);
            end
        end
    end

    initial begin
        int order[6] = '{0, 1, 2, 3, 0, 1};
        int skip[3]  = '{3, 1, 3};

        // Reset state, with every requester valid.
        load_table();
        req_valid = '1;
        step();
        check("ready_in_reset", int'(req_ready), 0);
        check("add_x_reset",    int'(add_x),     0);
        check("add_y_reset",    int'(add_y),     0);
        check("add_cin_reset",  int'(add_cin),   0);
        check("rsp_valid_reset", int'(rsp_valid), 0);
        check("rsp_id_reset",   int'(rsp_id),    0);

        // Fairness: all valid continuously from reset.
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            grant_is("grant_fair", 1 << order[k]);
            expect_rsp(order[k], tsum[order[k]], 0);
            step();
        end

        // Skip idle requesters: only 1 and 3 valid, pointer at 2.
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            grant_is("grant_skip", 1 << skip[k]);
            expect_rsp(skip[k], tsum[skip[k]], 0);
            step();
        end
        req_valid = '0;
        step();

        // Single request.
        set_req(0, 8'h11, 8'h22, 1'b1);
        req_valid = 4'b0001;
        grant_is("grant_single", 4'b0001);
        expect_rsp(0, 'h034, 0);
        step();
        req_valid = '0;
        step();

        // Carry out and all-zero sum back to back.
        set_req(1, 8'h01, 8'hFF, 1'b0);
        req_valid = 4'b0010;
        grant_is("grant_carry", 4'b0010);
        expect_rsp(1, 'h100, 0);
        step();
        set_req(1, 8'h00, 8'h00, 1'b0);
        grant_is("grant_zero", 4'b0010);
        expect_rsp(1, 'h000, 1);
        step();
        req_valid = '0;
        step();

        // Reset right after a req2 transfer: its response must vanish.
        load_table();
        req_valid = 4'b0100;
        grant_is("grant_pre_rst", 4'b0100);
        step();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        req_valid = '1;
        grant_is("grant_post_rst", 4'b0001);
        expect_rsp(0, tsum[0], 0);
        step();
        req_valid = '0;
        step();

`ifdef ADDER_ARB_LOCK_EN
        // Locked burst on req2 with req0 competing; pointer sits at 1.
        set_req(2, 8'hFF, 8'h01, 1'b0);
        req_last  = 4'b1011;
        req_valid = 4'b0101;
        grant_is("grant_lock_b1", 4'b0100);
        expect_rsp(2, 'h100, 0);
        step();
        req_valid = 4'b0001;
        grant_is("grant_lock_wait", 4'b0000);
        step();
        set_req(2, 8'h00, 8'h00, 1'b0);
        req_last  = 4'b1111;
        req_valid = 4'b0101;
        grant_is("grant_lock_b2", 4'b0100);
        expect_rsp(2, 'h001, 0);
        step();
        req_valid = 4'b0001;
        grant_is("grant_lock_release", 4'b0001);
        expect_rsp(0, tsum[0], 0);
        step();
        req_valid = '0;
        step();
`endif

        // Drain: every expected response must arrive within a bounded time.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
        check("drain_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
